div_nr_ctrl: RTL

- Sequencer and register stage for the non-restoring divider; sits directly upstream of the registered add/subtract stage.
- Owns the partial-remainder register A (N+1 bits), quotient/shift register Q (N bits), divisor register M and the iteration counter.
- Each iteration it drives out_A/out_D and a one-cycle add or sub strobe, then consumes out_Add_Sub one cycle later (the adder has 1-cycle registered latency).

---
 rtl/div_nr_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/div_nr_ctrl.sv
// -----------------------------------------------------------------------------
// div_nr_ctrl
// Sequencer and register stage of an N-bit unsigned non-restoring divider.
// Owns the partial remainder A (N+1 bits), the quotient/shift register Q,
// the divisor register M and the iteration counter. The add/subtract itself
// happens in an external stage with one cycle of registered latency: this
// block presents out_A/out_D with a one-cycle add or sub strobe and picks up
// out_Add_Sub in the following cycle.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset (shared with the adder stage)
//   start        division request, only honoured in IDLE
//   dividend     unsigned dividend, captured on an accepted start
//   divisor      unsigned divisor, captured on an accepted start
//   out_Add_Sub  registered result from the add/subtract stage
//   out_A        adder operand A (register A)
//   out_D        adder operand D ({1'b0, M})
//   add / sub    one-cycle adder strobes (A+D / A-D), never both high
//   quotient     result quotient, valid with done, held until next completion
//   remainder    result remainder, valid with done, held until next completion
//   busy         high from the cycle after start is accepted through DONE
//   done         one-cycle completion pulse (high while in DONE)
//   div_by_zero  set with done when the divisor was 0, cleared on next start
// -----------------------------------------------------------------------------
module div_nr_ctrl #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    input  logic [N:0]   out_Add_Sub,
    output logic [N:0]   out_A,
    output logic [N:0]   out_D,
    output logic         add,
    output logic         sub,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SHIFT    = 3'd1,
        S_OP       = 3'd2,
        S_UPD      = 3'd3,
        S_CORR_OP  = 3'd4,
        S_CORR_UPD = 3'd5,
        S_DONE     = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic [N:0]    a_q, a_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  m_q, m_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s_q, s_d;      // sign of A before the most recent shift
    logic          z_q, z_d;      // captured divisor was zero
    logic          add_q, add_d;
    logic          sub_q, sub_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dz_q, dz_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rem_q, rem_d;

    // Next-state and datapath update for the division sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        z_d     = z_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = '0;
                    q_d     = dividend;
                    m_d     = divisor;
                    cnt_d   = '0;
                    z_d     = (divisor == {N{1'b0}});
                    state_d = (divisor == {N{1'b0}}) ? S_DONE : S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                s_d = a_q[N];
                // 2N+1-bit left shift of {A,Q}; the old MSB of A drops out.
                {a_d, q_d} = {a_q[N-1:0], q_q, 1'b0};
                state_d = S_OP;
            end
            S_OP: begin
                state_d = S_UPD;
            end
            S_UPD: begin
                a_d    = out_Add_Sub;
                q_d[0] = ~out_Add_Sub[N];
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    // Negative final remainder needs one restoring add.
                    state_d = out_Add_Sub[N] ? S_CORR_OP : S_DONE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_CORR_OP: begin
                state_d = S_CORR_UPD;
            end
            S_CORR_UPD: begin
                a_d     = out_Add_Sub;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs are computed from the next state so they line up
    // with the state they belong to (strobe in OP, done while in DONE).
    always_comb begin
        add_d  = ((state_d == S_OP) && s_d) || (state_d == S_CORR_OP);
        sub_d  = (state_d == S_OP) && !s_d;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        quo_d  = quo_q;
        rem_d  = rem_q;
        dz_d   = dz_q;
        if ((state_q == S_IDLE) && start) begin
            dz_d = 1'b0;
        end else begin
            dz_d = dz_q;
        end
        // Results are loaded on entry to DONE so they are valid with done.
        if (state_d == S_DONE) begin
            if (z_d) begin
                quo_d = {N{1'b1}};
                rem_d = q_d;          // Q still holds the unshifted dividend
                dz_d  = 1'b1;
            end else begin
                quo_d = q_d;
                rem_d = a_d[N-1:0];
            end
        end else begin
            quo_d = quo_q;
            rem_d = rem_q;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            s_q     <= 1'b0;
            z_q     <= 1'b0;
            add_q   <= 1'b0;
            sub_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            z_q     <= z_d;
            add_q   <= add_d;
            sub_q   <= sub_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    assign out_A       = a_q;
    assign out_D       = {1'b0, m_q};
    assign add         = add_q;
    assign sub         = sub_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dz_q;

endmodule
